radial_zone_cfg_writer: RTL and testbench

- Produces the per-zone threshold tables and radial center that feed the radial confidence/depth filter: `c`, `z`, `r_squared`, `col_center` and `row_center`.
- A host writes values through a valid/ready register port into a shadow bank.
- A commit copies the shadow bank to the active outputs atomically at the next frame start, so the filter never sees a half-updated parameter set within a frame.

---
 rtl/radial_zone_cfg_writer.sv | 171 +++++++++++++++++
 tb/tb_radial_zone_cfg_writer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radial_zone_cfg_writer.sv
`default_nettype none
// =============================================================================
// Module      : radial_zone_cfg_writer
// Description : Shadow/active register bank for the radial confidence/depth
//               filter. Host writes land in a shadow bank; a commit copies the
//               whole shadow bank to the active outputs in a single edge.
// Revision    : 1.0 - initial release
// =============================================================================
module radial_zone_cfg_writer #(
    parameter int NO_ZONES      = 1,
    parameter bit SYNC_TO_FRAME = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [7:0]               wr_addr_i,
    input  logic [17:0]              wr_data_i,
    input  logic                     frame_start_i,
    output logic [16*NO_ZONES-1:0]   c_o,
    output logic [16*NO_ZONES-1:0]   z_o,
    output logic [18*NO_ZONES-1:0]   r_squared_o,
    output logic [15:0]              col_center_o,
    output logic [15:0]              row_center_o,
    output logic                     pending_o,
    output logic                     err_o
);

    localparam logic [5:0]  c_zone_cnt    = 6'(NO_ZONES);
    localparam logic [15:0] c_z_rst       = 16'h7BFF;   // largest finite fp16
    localparam logic [7:0]  c_addr_col    = 8'hF0;
    localparam logic [7:0]  c_addr_row    = 8'hF1;
    localparam logic [7:0]  c_addr_commit = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic wr_fire_w;
    logic zone_hit_w;
    logic mapped_w;
    logic commit_w;
    logic swap_w;
    logic err_q;

    logic [15:0] col_sh_q, row_sh_q;
    logic [15:0] col_act_q, row_act_q;

    // Acceptance depends only on the state register, so no loop through wr_ready_o.
    assign wr_fire_w  = wr_valid_i && (state_q == ST_IDLE);
    assign zone_hit_w = (wr_addr_i[1:0] != 2'b11) && (wr_addr_i[7:2] < c_zone_cnt);
    assign mapped_w   = zone_hit_w || (wr_addr_i == c_addr_col) ||
                        (wr_addr_i == c_addr_row) || (wr_addr_i == c_addr_commit);
    assign commit_w   = wr_fire_w && (wr_addr_i == c_addr_commit);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and swap strobe; a frame pulse in the commit cycle is
    // seen while still IDLE and therefore ignored.
    always_comb begin
        state_d    = state_q;
        wr_ready_o = 1'b0;
        pending_o  = 1'b0;
        swap_w     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ready_o = 1'b1;
                if (commit_w) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                pending_o = 1'b1;
                if (frame_start_i || !SYNC_TO_FRAME) begin
                    swap_w  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-cycle error pulse for an accepted write to an unmapped address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wr_fire_w && !mapped_w;
        end
    end

    assign err_o = err_q;

    // Center shadow registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col_sh_q <= '0;
            row_sh_q <= '0;
        end else if (wr_fire_w) begin
            if (wr_addr_i == c_addr_col) col_sh_q <= wr_data_i[15:0];
            if (wr_addr_i == c_addr_row) row_sh_q <= wr_data_i[15:0];
        end
    end

    // Center active registers, loaded together with every zone field.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col_act_q <= '0;
            row_act_q <= '0;
        end else if (swap_w) begin
            col_act_q <= col_sh_q;
            row_act_q <= row_sh_q;
        end
    end

    assign col_center_o = col_act_q;
    assign row_center_o = row_act_q;

    for (genvar k = 0; k < NO_ZONES; k++) begin : g_zone
        logic [15:0] c_sh_q, z_sh_q, c_act_q, z_act_q;
        logic [17:0] r_sh_q, r_act_q;
        logic        sel_w;

        assign sel_w = wr_fire_w && (wr_addr_i[7:2] == 6'(k));

        // Zone shadow fields; field 3 of each zone is reserved and ignored.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                c_sh_q <= '0;
                z_sh_q <= c_z_rst;
                r_sh_q <= '0;
            end else if (sel_w) begin
                case (wr_addr_i[1:0])
                    2'd0:    c_sh_q <= wr_data_i[15:0];
                    2'd1:    z_sh_q <= wr_data_i[15:0];
                    2'd2:    r_sh_q <= wr_data_i;
                    default: ;
                endcase
            end
        end

        // Zone active fields; shadow is kept so untouched fields re-send unchanged.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                c_act_q <= '0;
                z_act_q <= c_z_rst;
                r_act_q <= '0;
            end else if (swap_w) begin
                c_act_q <= c_sh_q;
                z_act_q <= z_sh_q;
                r_act_q <= r_sh_q;
            end
        end

        assign c_o[16*k +: 16]         = c_act_q;
        assign z_o[16*k +: 16]         = z_act_q;
        assign r_squared_o[18*k +: 18] = r_act_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_radial_zone_cfg_writer.sv
`default_nettype none
// =============================================================================
// Module      : tb_radial_zone_cfg_writer
// Description : Randomised scoreboard bench for radial_zone_cfg_writer
//               (NO_ZONES=2, frame-synchronised) plus a short directed run on
//               an unsynchronised instance.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_radial_zone_cfg_writer;

    localparam int NZ = 2;
    localparam bit SYNC = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // Main (frame-synchronised) instance
    logic            wr_valid = 1'b0;
    logic [7:0]      wr_addr  = '0;
    logic [17:0]     wr_data  = '0;
    logic            fs       = 1'b0;
    logic            wr_ready, pending, err;
    logic [16*NZ-1:0] c_o, z_o;
    logic [18*NZ-1:0] r_o;
    logic [15:0]     col_o, row_o;

    // Unsynchronised instance
    logic            v0 = 1'b0;
    logic [7:0]      a0 = '0;
    logic [17:0]     d0 = '0;
    logic            fs0 = 1'b0;
    logic            ready0, pending0, err0;
    logic [16*NZ-1:0] c0, z0;
    logic [18*NZ-1:0] r0;
    logic [15:0]     col0, row0;

    radial_zone_cfg_writer #(.NO_ZONES(NZ), .SYNC_TO_FRAME(SYNC)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .frame_start_i(fs),
        .c_o(c_o), .z_o(z_o), .r_squared_o(r_o),
        .col_center_o(col_o), .row_center_o(row_o),
        .pending_o(pending), .err_o(err)
    );

    radial_zone_cfg_writer #(.NO_ZONES(NZ), .SYNC_TO_FRAME(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_n),
        .wr_valid_i(v0), .wr_ready_o(ready0),
        .wr_addr_i(a0), .wr_data_i(d0),
        .frame_start_i(fs0),
        .c_o(c0), .z_o(z0), .r_squared_o(r0),
        .col_center_o(col0), .row_center_o(row0),
        .pending_o(pending0), .err_o(err0)
    );

    // Whole parameter set, laid out like the DUT output ports.
    typedef struct packed {
        logic [16*NZ-1:0] c;
        logic [16*NZ-1:0] z;
        logic [18*NZ-1:0] r;
        logic [15:0]      col;
        logic [15:0]      row;
    } cfg_t;

    cfg_t  sh;              // model shadow bank (driver side)
    cfg_t  exp_act;         // expected active outputs (monitor side)
    cfg_t  swap_q[$];       // snapshots taken at each accepted commit
    logic  exp_pending = 1'b0;
    logic  exp_err     = 1'b0;
    logic  mon_fire;
    int    errors = 0;
    int    checks = 0;

    function automatic cfg_t reset_cfg();
        cfg_t x;
        x.c   = '0;
        x.r   = '0;
        x.col = '0;
        x.row = '0;
        for (int k = 0; k < NZ; k++) x.z[16*k +: 16] = 16'h7BFF;
        return x;
    endfunction

    function automatic bit is_mapped(input logic [7:0] a);
        int k;
        k = int'(a[7:2]);
        return ((a[1:0] != 2'd3) && (k < NZ)) || (a == 8'hF0) || (a == 8'hF1) || (a == 8'hFF);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every cycle against the expected state, then advance the
    // expectation by the behaviour of the coming clock edge.
    initial begin
        exp_act = reset_cfg();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_act     = reset_cfg();
                exp_pending = 1'b0;
                exp_err     = 1'b0;
            end
            check("c_o",        64'(c_o),      64'(exp_act.c));
            check("z_o",        64'(z_o),      64'(exp_act.z));
            check("r_squared_o", 64'(r_o),     64'(exp_act.r));
            check("col_center", 64'(col_o),    64'(exp_act.col));
            check("row_center", 64'(row_o),    64'(exp_act.row));
            check("pending_o",  64'(pending),  64'(exp_pending));
            check("wr_ready_o", 64'(wr_ready), 64'(!exp_pending));
            check("err_o",      64'(err),      64'(exp_err));
            if (rst_n) begin
                mon_fire = wr_valid && !exp_pending;
                exp_err  = mon_fire && !is_mapped(wr_addr);
                if (exp_pending && (fs || !SYNC)) begin
                    if (swap_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL swap_queue: got empty expected a committed snapshot");
                    end else begin
                        exp_act = swap_q.pop_front();
                    end
                    exp_pending = 1'b0;
                end else if (mon_fire && (wr_addr == 8'hFF)) begin
                    exp_pending = 1'b1;
                end
            end
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [17:0] d);
        int n = 0;
        int k;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: got no ready expected ready within 50 cycles");
        end
        @(posedge clk);
        if (a == 8'hFF) begin
            swap_q.push_back(sh);
        end else if (is_mapped(a)) begin
            if (a == 8'hF0)      sh.col = d[15:0];
            else if (a == 8'hF1) sh.row = d[15:0];
            else begin
                k = int'(a[7:2]);
                case (a[1:0])
                    2'd0:    sh.c[16*k +: 16] = d[15:0];
                    2'd1:    sh.z[16*k +: 16] = d[15:0];
                    default: sh.r[18*k +: 18] = d;
                endcase
            end
        end
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic frame();
        fs = 1'b1;
        tick(1);
        fs = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sh    = reset_cfg();
        swap_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    function automatic logic [7:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 6);
        case (sel)
            0, 1, 2, 3: return {6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            4:          return 8'hF0;
            5:          return 8'hF1;
            default:    return 8'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sh = reset_cfg();
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Staged update: nothing visible until the frame pulse, then all at once.
        wr(8'h05, 18'h03C00);
        wr(8'h06, 18'h00100);
        wr(8'hF0, 18'd320);
        wr(8'hFF, 18'h0);
        tick(3);
        check("pre_swap_col", 64'(col_o), 64'd0);
        frame();
        check("swap_z1",   64'(z_o[31:16]), 64'h3C00);
        check("swap_r1",   64'(r_o[35:18]), 64'h100);
        check("swap_col",  64'(col_o),      64'd320);
        tick(2);

        // Commit coinciding with a frame pulse waits for the next pulse.
        fs = 1'b1;
        wr(8'hFF, 18'h0);
        fs = 1'b0;
        tick(3);
        check("late_pending", 64'(pending), 64'd1);
        frame();
        tick(2);

        // Unmapped zone index with NO_ZONES=2.
        wr(8'h08, 18'h3FFFF);
        check("err_pulse", 64'(err), 64'd1);
        wr(8'hFF, 18'h0);
        frame();
        check("unmapped_c1", 64'(c_o[31:16]), 64'd0);
        tick(2);

        // Reset while a swap is pending discards it.
        wr(8'h00, 18'h01234);
        wr(8'hFF, 18'h0);
        tick(1);
        do_reset();
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_z0",      64'(z_o[15:0]), 64'h7BFF);
        frame();
        check("rst_c0", 64'(c_o[15:0]), 64'd0);
        tick(2);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 9);
            fs = ($urandom_range(0, 5) == 0);
            if (pending) fs = 1'b1;
            case (op)
                0, 1, 2, 3, 4: wr(rand_addr(), 18'($urandom));
                5:             wr(8'hFF, 18'($urandom));
                6:             tick($urandom_range(1, 3));
                7, 8:          begin fs = 1'b1; tick(1); end
                default:       if ($urandom_range(0, 9) == 0) do_reset(); else tick(1);
            endcase
            fs = 1'b0;
        end
        fs = 1'b1;
        tick(2);
        fs = 1'b0;
        tick(2);

        // Unsynchronised instance: commit at edge N, outputs new after edge N+1.
        v0 = 1'b1;
        a0 = 8'h00;
        d0 = 18'h02000;
        tick(1);
        a0 = 8'hFF;
        tick(1);
        v0 = 1'b0;
        @(negedge clk);
        check("nosync_c0_before", 64'(c0[15:0]), 64'd0);
        check("nosync_pending",   64'(pending0), 64'd1);
        check("nosync_ready",     64'(ready0),   64'd0);
        @(negedge clk);
        check("nosync_c0_after",  64'(c0[15:0]), 64'h2000);
        check("nosync_idle",      64'(pending0), 64'd0);
        check("nosync_ready_back", 64'(ready0),  64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
